game_cursor_draw: RTL

- VGA pipeline stage directly downstream of the game board grid draw stage.
- Keeps the player's selected cell (row, col) on the board and moves it on single-cycle direction pulses, with wrap-around at the board edges.
- Overlays a 1-pixel cursor frame on the selected 16x16 cell, on top of the grid image.
- Forwards all timing signals with one cycle of latency and exports the cursor position to the game logic.

---
 rtl/game_cursor_draw_if.sv | 14 +
 rtl/game_cursor_draw.sv | 135 +++++++++++++
 2 files changed

// File: rtl/game_cursor_draw_if.sv
// VGA pixel stream bundle shared by the draw pipeline stages.
// Streaming, no backpressure: the master updates every field on every pixel clock and the slave takes each beat.
interface vga_bus;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, hblnk, vsync, vblnk, rgb);
endinterface

// File: rtl/game_cursor_draw.sv
// Cursor overlay stage: keeps the selected board cell and draws a 1-px frame around it.
// Optional blinking of the frame is enabled with GAME_CURSOR_BLINK_EN.
module game_cursor_draw #(
  parameter logic [11:0] CURSOR_COLOR = 12'hF00,
  parameter int          BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       is_game_on,
  input  logic [2:0] board_size,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       move_left,
  input  logic       move_right,
  output logic [3:0] cursor_row,
  output logic [3:0] cursor_col,
  vga_bus.slave      bus_in,
  vga_bus.master     bus_out
);

  logic [4:0]  n;
  logic [3:0]  last;
  logic        size_ok;
  logic [15:0] x0, y0, cell_x, cell_y, hx, vy;
  logic [3:0]  lx, ly;
  logic        in_cell, on_frame, visible, draw;
  logic [3:0]  row_n, col_n;
  logic [3:0]  srow, scol;
  logic [2:0]  prev_size;
  logic        vsync_q, vsync_rise, any_move, force_home;

  assign n          = 5'(board_size) * 5'(board_size);
  assign last       = 4'(n - 5'd1);
  assign size_ok    = (board_size >= 3'd2) && (board_size <= 3'd4);
  assign vsync_rise = bus_in.vsync && !vsync_q;
  assign any_move   = move_up | move_down | move_left | move_right;
  assign force_home = !is_game_on || !size_ok || (board_size != prev_size);

  // Geometry of the shadow cell in 16-bit screen coordinates.
  assign x0     = (16'd1024 - {7'd0, n, 4'd0}) >> 1;
  assign y0     = (16'd768 - {7'd0, n, 4'd0}) >> 1;
  assign cell_x = x0 + {8'd0, scol, 4'd0};
  assign cell_y = y0 + {8'd0, srow, 4'd0};
  assign hx     = {5'd0, bus_in.hcount};
  assign vy     = {5'd0, bus_in.vcount};
  assign lx     = 4'(hx - cell_x);
  assign ly     = 4'(vy - cell_y);
  assign in_cell  = (hx >= cell_x) && (hx <= cell_x + 16'd15) &&
                    (vy >= cell_y) && (vy <= cell_y + 16'd15);
  assign on_frame = in_cell && ((lx == 4'd0) || (lx == 4'd15) || (ly == 4'd0) || (ly == 4'd15));
  assign draw     = is_game_on && size_ok && on_frame && visible;

  // Opposing pulses cancel on their axis; one horizontal and one vertical move may combine.
  always_comb begin
    row_n = cursor_row;
    col_n = cursor_col;
    if (move_right && !move_left)
      col_n = (cursor_col == last) ? 4'd0 : cursor_col + 4'd1;
    else if (move_left && !move_right)
      col_n = (cursor_col == 4'd0) ? last : cursor_col - 4'd1;
    if (move_down && !move_up)
      row_n = (cursor_row == last) ? 4'd0 : cursor_row + 4'd1;
    else if (move_up && !move_down)
      row_n = (cursor_row == 4'd0) ? last : cursor_row - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor_row <= 4'd0;
      cursor_col <= 4'd0;
      srow       <= 4'd0;
      scol       <= 4'd0;
      prev_size  <= 3'd0;
      vsync_q    <= 1'b0;
    end else begin
      prev_size <= board_size;
      vsync_q   <= bus_in.vsync;
      if (force_home) begin
        cursor_row <= 4'd0;
        cursor_col <= 4'd0;
        srow       <= 4'd0;
        scol       <= 4'd0;
      end else begin
        cursor_row <= row_n;
        cursor_col <= col_n;
        // Shadow only changes at frame start so the drawn cursor never tears.
        if (vsync_rise) begin
          srow <= cursor_row;
          scol <= cursor_col;
        end
      end
    end
  end

`ifdef GAME_CURSOR_BLINK_EN
  localparam int CW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] BLINK_HALF = CW'(BLINK_FRAMES / 2);
  logic [CW-1:0] blink_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      blink_cnt <= '0;
    else if (any_move)
      blink_cnt <= '0;
    else if (vsync_rise)
      blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
  end

  assign visible = (blink_cnt < BLINK_HALF);
`else
  assign visible = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_out.hcount <= 11'd0;
      bus_out.vcount <= 11'd0;
      bus_out.hsync  <= 1'b0;
      bus_out.hblnk  <= 1'b0;
      bus_out.vsync  <= 1'b0;
      bus_out.vblnk  <= 1'b0;
      bus_out.rgb    <= 12'd0;
    end else begin
      bus_out.hcount <= bus_in.hcount;
      bus_out.vcount <= bus_in.vcount;
      bus_out.hsync  <= bus_in.hsync;
      bus_out.hblnk  <= bus_in.hblnk;
      bus_out.vsync  <= bus_in.vsync;
      bus_out.vblnk  <= bus_in.vblnk;
      bus_out.rgb    <= draw ? CURSOR_COLOR : bus_in.rgb;
    end
  end

endmodule
